hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Pipeline hazard and stall controller for the 5-stage MIPS core. Owns the
//  hold/flush of every pipeline latch and the PC: load-use bubbles, I-fetch
//  miss bubbles, D-mem wait freezes, taken-branch/jump squashes and the halt
//  latch. It keeps the EX-stage operand path valid whenever the forwarding
//  unit can supply an operand, and stalls whenever it cannot. Counts stall
//  and flush cycles for perf.
// PARAMETERS
//  CNT_W   32  width of stall_cnt / flush_cnt saturating perf counters
// PORTS
//  CLK          in   1      core clock, all state rises on posedge
//  RST          in   1      asynchronous, active-high reset
//  ihit         in   1      instruction fetch completed this cycle
//  dhit         in   1      data access in MEM completed this cycle
//  id_rs,id_rt  in   5      source regs of instruction in ID
//  id_use_rs    in   1      ID instruction reads rs
//  id_use_rt    in   1      ID instruction reads rt
//  ex_MemRead   in   1      instruction in EX is a load
//  ex_WrDest    in   5      destination reg of instruction in EX
//  ex_pc_redir  in   1      taken branch / jump / jr resolved in EX
//  mem_dREN     in   1      MEM-stage load request
//  mem_dWEN     in   1      MEM-stage store request
//  wb_halt      in   1      halt instruction has reached WB
//  pc_en        out  1      PC register update enable
//  ifid_en      out  1      IF/ID latch enable
//  idex_en      out  1      ID/EX latch enable
//  exmem_en     out  1      EX/MEM latch enable
//  memwb_en     out  1      MEM/WB latch enable
//  ifid_flush   out  1      load bubble into IF/ID (when enabled)
//  idex_flush   out  1      load bubble into ID/EX (when enabled)
//  memwb_flush  out  1      load bubble into MEM/WB
//  halted       out  1      core halted (registered)
//  stall_cnt    out  CNT_W  cycles with pc_en=0 while RUN/MEMWAIT
//  flush_cnt    out  CNT_W  cycles with ifid_flush or idex_flush=1
// BEHAVIOUR
//  FSM states: RUN, MEMWAIT, HALT. Reset -> RUN, halted=0, counters=0.
//  While RST=1: all *_en=0, all *_flush=0.
//  Conditions (combinational, evaluated every cycle):
//   memreq = mem_dREN|mem_dWEN ; memstall = memreq & ~dhit
//   loaduse = ex_MemRead & ex_WrDest!=0 & ((id_use_rs & ex_WrDest==id_rs)
//             | (id_use_rt & ex_WrDest==id_rt))
//  Priority in RUN/MEMWAIT (highest first):
//   1 memstall: pc/ifid/idex/exmem_en=0; memwb_en=1, memwb_flush=1.
//     Next state MEMWAIT. Redirect/load-use are NOT acted on this cycle;
//     they re-evaluate once the freeze lifts (inputs are held by latches).
//   2 ex_pc_redir: pc_en=1, ifid_en=idex_en=1, ifid_flush=idex_flush=1,
//     exmem/memwb_en=1. Squashes IF and ID regardless of ihit/loaduse.
//   3 loaduse: pc_en=ifid_en=0; idex_en=1, idex_flush=1; exmem/memwb_en=1.
//     Exactly one bubble per load: next cycle load is in MEM, loaduse=0.
//   4 ~ihit: pc_en=0; ifid_en=1, ifid_flush=1; later stages enabled.
//   5 else: all enables 1, no flush.
//  MEMWAIT -> RUN on the cycle dhit=1 (that cycle uses rows 2-5).
//  wb_halt=1 in RUN/MEMWAIT -> HALT next edge; HALT: all en=0, halted=1,
//   stays until RST. wb_halt has priority over every other condition.
//  Counters: +1 per qualifying cycle, saturate at all-ones, frozen in HALT.
//  Reset mid-MEMWAIT: immediate return to RUN, no residual stall.
// TESTING
//  1 ex_MemRead=1,ex_WrDest=8,id_rs=8,id_use_rs=1,ihit=1 -> 1 cycle pc_en=0,
//    idex_flush=1; next cycle (load in MEM, dhit=1) all en=1; stall_cnt=1.
//  2 same but ex_WrDest=0 -> no stall; id_use_rt=0 with id_rt=8 -> no stall.
//  3 mem_dREN=1, dhit=0 for 3 cycles then 1 -> 3 cycles pc/ifid/idex/exmem
//    _en=0 + memwb_flush=1, state MEMWAIT; 4th cycle RUN, all en=1.
//  4 ex_pc_redir=1 with loaduse=1 and ihit=0 -> ifid_flush=idex_flush=1,
//    pc_en=1; flush_cnt +1.
//  5 ex_pc_redir=1 during memstall -> freeze only; redirect acts the cycle
//    dhit rises.
//  6 wb_halt=1 -> next edge halted=1, all en=0; counters frozen; RST pulse
//    mid-MEMWAIT -> RUN, counters 0.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Hazard and stall controller for the 5-stage pipeline: drives every latch
// enable/flush and the PC enable, tracks the D-mem freeze and halt, and keeps
// saturating perf counters for stall and flush cycles.
module hazard_stall_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_WrDest,
    input  logic             ex_pc_redir,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic memreq;
    logic memstall;
    logic loaduse;
    logic rs_hit;
    logic rt_hit;

    // Hazard conditions seen by the current cycle
    always_comb begin
        memreq   = mem_dREN | mem_dWEN;
        memstall = memreq & ~dhit;
        rs_hit   = id_use_rs & (ex_WrDest == id_rs);
        rt_hit   = id_use_rt & (ex_WrDest == id_rt);
        loaduse  = ex_MemRead & (ex_WrDest != REG_W'(0)) & (rs_hit | rt_hit);
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and prioritised latch control; everything idles under reset
    always_comb begin
        state_next  = state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        case (state)
            HALT: begin
                state_next = HALT;
            end
            default: begin
                if (wb_halt) begin
                    // Halt retiring: freeze everything and park
                    state_next = HALT;
                end else if (memstall) begin
                    // Freeze front of pipe, drain a bubble into WB
                    state_next  = MEMWAIT;
                    memwb_en    = 1'b1;
                    memwb_flush = 1'b1;
                end else begin
                    state_next = RUN;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    idex_en    = 1'b1;
                    if (ex_pc_redir) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (loaduse) begin
                        idex_flush = 1'b1;
                    end else if (!ihit) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                end
            end
        endcase
        if (RST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            memwb_flush = 1'b0;
        end
    end

    // Halt flag, set on entry to HALT and held until reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halted <= 1'b0;
        end else begin
            halted <= (state_next == HALT);
        end
    end

    // Saturating stall/flush perf counters, frozen once halted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state != HALT) begin
            if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((ifid_flush || idex_flush) && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use, fetch miss, D-mem freeze,
// redirect squash, halt, reset and counter saturation.
module tb_hazard_stall_unit;

    localparam int unsigned CW = 4;

    // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, memwb_fl}
    localparam logic [7:0] C_ZERO = 8'b00000_000;
    localparam logic [7:0] C_RUN  = 8'b11111_000;
    localparam logic [7:0] C_LU   = 8'b00111_010;
    localparam logic [7:0] C_MS   = 8'b00001_001;
    localparam logic [7:0] C_RD   = 8'b11111_110;
    localparam logic [7:0] C_IM   = 8'b01111_100;

    logic          clk;
    logic          rst;
    logic          ihit, dhit;
    logic [4:0]    id_rs, id_rt, ex_WrDest;
    logic          id_use_rs, id_use_rt, ex_MemRead, ex_pc_redir;
    logic          mem_dREN, mem_dWEN, wb_halt;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, memwb_flush, halted;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [7:0]    ctl;

    int total = 0;
    int bad   = 0;

    hazard_stall_unit #(.CNT_W(CW)) dut (
        .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_MemRead(ex_MemRead), .ex_WrDest(ex_WrDest), .ex_pc_redir(ex_pc_redir),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_flush(memwb_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, memwb_flush};

    always #5 clk = ~clk;

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_MemRead = 1'b0; ex_WrDest = 5'd0; ex_pc_redir = 1'b0;
        mem_dREN = 1'b0; mem_dWEN = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #12;
        total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_ZERO); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        total++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL reset_run got=%b exp=%b", ctl, C_RUN); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_MemRead = 1'b1; ex_WrDest = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
        #1;
        total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_bubble got=%b exp=%b", ctl, C_LU); end
        @(negedge clk);
        ex_MemRead = 1'b0; mem_dREN = 1'b1; dhit = 1'b1;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL lu_release got=%b exp=%b", ctl, C_RUN); end
        total++; if (stall_cnt !== 4'd1 || flush_cnt !== 4'd1) begin bad++; $display("FAIL lu_cnt got=%0d/%0d exp=1/1", stall_cnt, flush_cnt); end
        @(negedge clk);
        idle();
        #1;
        total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_single got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_no_hazard();
        do_reset();
        ex_MemRead = 1'b1; ex_WrDest = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL nh_r0 got=%b exp=%b", ctl, C_RUN); end
        @(negedge clk);
        ex_WrDest = 5'd8; id_rt = 5'd8; id_use_rt = 1'b0; id_rs = 5'd3; id_use_rs = 1'b1;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL nh_rt_unused got=%b exp=%b", ctl, C_RUN); end
        @(negedge clk);
        id_use_rt = 1'b1;
        #1;
        total++; if (ctl !== C_LU) begin bad++; $display("FAIL nh_rt_used got=%b exp=%b", ctl, C_LU); end
        @(negedge clk);
        ex_MemRead = 1'b0;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL nh_not_load got=%b exp=%b", ctl, C_RUN); end
        total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL nh_cnt got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_memwait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            mem_dREN = 1'b1; dhit = 1'b0;
            #1;
            total++; if (ctl !== C_MS) begin bad++; $display("FAIL mw_freeze%0d got=%b exp=%b", i, ctl, C_MS); end
        end
        @(negedge clk);
        dhit = 1'b1;
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL mw_release got=%b exp=%b", ctl, C_RUN); end
        total++; if (stall_cnt !== 4'd3 || flush_cnt !== 4'd0) begin bad++; $display("FAIL mw_cnt got=%0d/%0d exp=3/0", stall_cnt, flush_cnt); end
        @(negedge clk);
        idle();
        #1;
        total++; if (ctl !== C_RUN || stall_cnt !== 4'd3) begin bad++; $display("FAIL mw_after got=%b/%0d exp=%b/3", ctl, stall_cnt, C_RUN); end
    endtask

    task automatic test_redirect();
        do_reset();
        ex_pc_redir = 1'b1; ex_MemRead = 1'b1; ex_WrDest = 5'd9;
        id_rt = 5'd9; id_use_rt = 1'b1; ihit = 1'b0;
        #1;
        total++; if (ctl !== C_RD) begin bad++; $display("FAIL rd_squash got=%b exp=%b", ctl, C_RD); end
        @(negedge clk);
        idle();
        ihit = 1'b0;
        #1;
        total++; if (ctl !== C_IM) begin bad++; $display("FAIL rd_imiss got=%b exp=%b", ctl, C_IM); end
        total++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd1) begin bad++; $display("FAIL rd_cnt got=%0d/%0d exp=0/1", stall_cnt, flush_cnt); end
        @(negedge clk);
        idle();
        #1;
        total++; if (stall_cnt !== 4'd1 || flush_cnt !== 4'd2) begin bad++; $display("FAIL rd_cnt2 got=%0d/%0d exp=1/2", stall_cnt, flush_cnt); end
    endtask

    task automatic test_redir_memstall();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            if (i != 0) @(negedge clk);
            ex_pc_redir = 1'b1; mem_dWEN = 1'b1; dhit = 1'b0;
            #1;
            total++; if (ctl !== C_MS) begin bad++; $display("FAIL rm_freeze%0d got=%b exp=%b", i, ctl, C_MS); end
        end
        @(negedge clk);
        dhit = 1'b1;
        #1;
        total++; if (ctl !== C_RD) begin bad++; $display("FAIL rm_redir got=%b exp=%b", ctl, C_RD); end
        total++; if (stall_cnt !== 4'd2 || flush_cnt !== 4'd0) begin bad++; $display("FAIL rm_cnt got=%0d/%0d exp=2/0", stall_cnt, flush_cnt); end
        @(negedge clk);
        idle();
        #1;
        total++; if (ctl !== C_RUN || flush_cnt !== 4'd1) begin bad++; $display("FAIL rm_after got=%b/%0d exp=%b/1", ctl, flush_cnt, C_RUN); end
    endtask

    task automatic test_halt();
        do_reset();
        ihit = 1'b0;
        @(negedge clk);
        ihit = 1'b1; wb_halt = 1'b1; mem_dREN = 1'b1; dhit = 1'b0;
        @(negedge clk);
        idle();
        #1;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
        total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL halt_ctl got=%b exp=%b", ctl, C_ZERO); end
        total++; if (stall_cnt !== 4'd2 || flush_cnt !== 4'd1) begin bad++; $display("FAIL halt_cnt got=%0d/%0d exp=2/1", stall_cnt, flush_cnt); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ihit = 1'b0; ex_pc_redir = 1'b1; mem_dREN = 1'b1;
            #1;
            total++; if (ctl !== C_ZERO || halted !== 1'b1) begin bad++; $display("FAIL halt_hold%0d got=%b/%b exp=%b/1", i, ctl, halted, C_ZERO); end
        end
        @(negedge clk);
        idle();
        #1;
        total++; if (stall_cnt !== 4'd2 || flush_cnt !== 4'd1) begin bad++; $display("FAIL halt_frozen got=%0d/%0d exp=2/1", stall_cnt, flush_cnt); end
        #2 rst = 1'b1;
        #1;
        total++; if (halted !== 1'b0 || stall_cnt !== 4'd0) begin bad++; $display("FAIL halt_rst got=%b/%0d exp=0/0", halted, stall_cnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_memwait();
        do_reset();
        mem_dREN = 1'b1; dhit = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL rmw_ctl got=%b exp=%b", ctl, C_ZERO); end
        total++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || halted !== 1'b0) begin bad++; $display("FAIL rmw_state got=%0d/%0d/%b exp=0/0/0", stall_cnt, flush_cnt, halted); end
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        total++; if (ctl !== C_RUN) begin bad++; $display("FAIL rmw_run got=%b exp=%b", ctl, C_RUN); end
        @(negedge clk);
        #1;
        total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL rmw_nostall got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        ihit = 1'b0;
        repeat (20) @(negedge clk);
        idle();
        #1;
        total++; if (stall_cnt !== 4'hF || flush_cnt !== 4'hF) begin bad++; $display("FAIL sat got=%0d/%0d exp=15/15", stall_cnt, flush_cnt); end
    endtask

    initial begin
        clk = 1'b0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_memwait();
        test_redirect();
        test_redir_memstall();
        test_halt();
        test_reset_memwait();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
